// File: rtl/sram_arb_pkg.sv
// Shared constants for the SRAM22 round-robin arbiter.
// Optional counters are enabled with the SRAM_ARB_PERF_EN macro.
package sram_arb_pkg;

  localparam int PERF_CNT_WIDTH = 16;
  localparam int MAX_NUM_REQ    = 4;

  // Round-robin pointer width; a single requester index still needs one bit.
  function automatic int RR_PTR_WIDTH(input int num_req);
    return (num_req <= 2) ? 1 : $clog2(num_req);
  endfunction

endpackage

// File: rtl/sram_arb_rr_picker.sv
// Combinational round-robin picker: first eligible port at or after rr_ptr wins.
module sram_arb_rr_picker
  import sram_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = RR_PTR_WIDTH(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   grant_idx
);

  logic [PTR_W-1:0] idx;

  // Scan from the farthest offset down so the closest eligible port overwrites.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    idx       = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = PTR_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (eligible[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/sram22_rr_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM22 macro between NUM_REQ requesters.
// Define SRAM_ARB_PERF_EN to add per-port saturating grant/stall counters.
module sram22_rr_arbiter
  import sram_arb_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 6,
  parameter int WMASK_WIDTH = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ-1:0]             req_we,
  input  logic [NUM_REQ*WMASK_WIDTH-1:0] req_wmask,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]             resp_valid,
  input  logic [NUM_REQ-1:0]             resp_ready,
  output logic [NUM_REQ*DATA_WIDTH-1:0]  resp_rdata,
  output logic                           sram_we,
  output logic [WMASK_WIDTH-1:0]         sram_wmask,
  output logic [ADDR_WIDTH-1:0]          sram_addr,
  output logic [DATA_WIDTH-1:0]          sram_din,
  input  logic [DATA_WIDTH-1:0]          sram_dout
`ifdef SRAM_ARB_PERF_EN
  ,
  output logic [NUM_REQ*PERF_CNT_WIDTH-1:0] perf_grants,
  output logic [NUM_REQ*PERF_CNT_WIDTH-1:0] perf_stalls
`endif
);

  localparam int PTR_W = RR_PTR_WIDTH(NUM_REQ);

  // Handshake: a request transfers when req_valid && req_ready; a response
  // transfers when resp_valid && resp_ready. Requesters hold req_* while stalled.

  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   grant_idx;
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] inflight;

  // A read may only issue when its response slot will be free on capture.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i] = !reset && req_valid[i] &&
                    (req_we[i] || (!inflight[i] && (!resp_valid[i] || resp_ready[i])));
    end
  end

  sram_arb_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_picker (
    .eligible  (eligible),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign req_ready = grant;

  always_comb begin
    sram_we    = 1'b0;
    sram_wmask = '0;
    sram_addr  = '0;
    sram_din   = '0;
    if (|grant) begin
      sram_we    = req_we[grant_idx];
      sram_wmask = req_wmask[int'(grant_idx)*WMASK_WIDTH +: WMASK_WIDTH];
      sram_addr  = req_addr[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
      sram_din   = req_wdata[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // inflight marks the port whose read data is on sram_dout this cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr     <= '0;
      inflight   <= '0;
      resp_valid <= '0;
      resp_rdata <= '0;
    end else begin
      inflight <= grant & ~req_we;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (inflight[i]) begin
          resp_valid[i]                         <= 1'b1;
          resp_rdata[i*DATA_WIDTH +: DATA_WIDTH] <= sram_dout;
        end else if (resp_ready[i]) begin
          resp_valid[i] <= 1'b0;
        end
      end
      if (|grant) begin
        rr_ptr <= (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
      end
    end
  end

`ifdef SRAM_ARB_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_grants <= '0;
      perf_stalls <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant[i] && (perf_grants[i*PERF_CNT_WIDTH +: PERF_CNT_WIDTH] != '1)) begin
          perf_grants[i*PERF_CNT_WIDTH +: PERF_CNT_WIDTH] <=
            perf_grants[i*PERF_CNT_WIDTH +: PERF_CNT_WIDTH] + 1'b1;
        end
        if (req_valid[i] && !grant[i] &&
            (perf_stalls[i*PERF_CNT_WIDTH +: PERF_CNT_WIDTH] != '1)) begin
          perf_stalls[i*PERF_CNT_WIDTH +: PERF_CNT_WIDTH] <=
            perf_stalls[i*PERF_CNT_WIDTH +: PERF_CNT_WIDTH] + 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_sram22_rr_arbiter.sv
// Bench for sram22_rr_arbiter (2 ports) with a behavioural SRAM22 macro model.
// Counter checks are compiled in when SRAM_ARB_PERF_EN is defined.
module tb_sram22_rr_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_ready;
  logic [1:0]  req_we = '0;
  logic [1:0]  req_wmask = '0;
  logic [11:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic [1:0]  resp_valid;
  logic [1:0]  resp_ready = '0;
  logic [63:0] resp_rdata;
  logic        sram_we;
  logic [0:0]  sram_wmask;
  logic [5:0]  sram_addr;
  logic [31:0] sram_din;
  logic [31:0] sram_dout;
`ifdef SRAM_ARB_PERF_EN
  logic [31:0] perf_grants;
  logic [31:0] perf_stalls;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  sram22_rr_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_wmask  (req_wmask),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .sram_we    (sram_we),
    .sram_wmask (sram_wmask),
    .sram_addr  (sram_addr),
    .sram_din   (sram_din),
    .sram_dout  (sram_dout)
`ifdef SRAM_ARB_PERF_EN
    ,
    .perf_grants (perf_grants),
    .perf_stalls (perf_stalls)
`endif
  );

  // 64x32 macro: synchronous read, write when we and wmask set, no reset.
  logic [31:0] mem [64];
  always @(posedge clk) begin
    if (sram_we) begin
      if (sram_wmask[0]) mem[sram_addr] <= sram_din;
    end else begin
      sram_dout <= mem[sram_addr];
    end
  end

  // Requesters must hold a stalled request unchanged.
  logic [1:0]  h_mask = '0;
  logic [1:0]  s_we;
  logic [11:0] s_addr;
  logic [63:0] s_wdata;
  always @(negedge clk) begin
    if (reset) begin
      h_mask = '0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (h_mask[p])
          assert (req_valid[p] && req_we[p] == s_we[p] &&
                  req_addr[p*6 +: 6] == s_addr[p*6 +: 6] &&
                  req_wdata[p*32 +: 32] == s_wdata[p*32 +: 32])
          else $error("requester %0d changed a stalled request", p);
      end
      h_mask  = req_valid & ~req_ready;
      s_we    = req_we;
      s_addr  = req_addr;
      s_wdata = req_wdata;
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic set_port(input int p, input logic v, input logic we,
                          input logic [5:0] a, input logic [31:0] d);
    req_valid[p]          = v;
    req_we[p]             = we;
    req_wmask[p]          = 1'b1;
    req_addr[p*6 +: 6]    = a;
    req_wdata[p*32 +: 32] = d;
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    req_valid  = '0;
    req_we     = '0;
    resp_ready = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  function automatic logic [31:0] pat(input int a);
    return 32'(a) * 32'h01010101;
  endfunction

  typedef struct {
    logic [1:0]  valid;
    logic [1:0]  we;
    logic [1:0]  rr;
    logic [5:0]  a0;
    logic [31:0] d0;
    logic [5:0]  a1;
    logic [31:0] d1;
    logic [1:0]  exp_ready;
    logic [1:0]  exp_rv;
    logic [31:0] exp_r0;
    logic [31:0] exp_r1;
  } vec_t;

  function automatic vec_t mk(input logic [1:0] valid, input logic [1:0] we, input logic [1:0] rr,
                              input logic [5:0] a0, input logic [31:0] d0,
                              input logic [5:0] a1, input logic [31:0] d1,
                              input logic [1:0] er, input logic [1:0] erv,
                              input logic [31:0] r0, input logic [31:0] r1);
    vec_t v;
    v.valid = valid; v.we = we; v.rr = rr;
    v.a0 = a0; v.d0 = d0; v.a1 = a1; v.d1 = d1;
    v.exp_ready = er; v.exp_rv = erv; v.exp_r0 = r0; v.exp_r1 = r1;
    return v;
  endfunction

  vec_t        tbl [25];
  logic [31:0] exp_q [$];

  // Reference model state for the random phase.
  logic [31:0] m_mem [64];
  bit          m_known [64];
  bit          m_rv [2];
  logic [31:0] m_rd [2];
  bit          m_rdk [2];
  int          m_ip;
  logic [31:0] m_id;
  bit          m_idk;
  int          m_rr;
  bit          held [2];

  initial begin
    int          lat;
    int          eg;
    int          pp;
    int          a;
    logic [31:0] rd;
    logic [1:0]  exp_ready;

    // Reset state, with both ports requesting.
    #1 reset = 1'b1;
    req_valid = 2'b11;
    req_we    = 2'b11;
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_resp_valid", 32'(resp_valid), 32'h0);
    chk("rst_rdata0", resp_rdata[31:0], 32'h0);
    chk("rst_rdata1", resp_rdata[63:32], 32'h0);
    chk("rst_sram_we", 32'(sram_we), 32'h0);
    do_reset();

    // Fill all 64 words through port 1, read back through port 0.
    resp_ready = 2'b11;
    for (int i = 0; i < 64; i++) begin
      set_port(1, 1'b1, 1'b1, 6'(i), pat(i));
      @(negedge clk);
      chk("fill_grant", 32'(req_ready), 32'h2);
      @(posedge clk); #1;
    end
    set_port(1, 1'b0, 1'b0, 6'd0, 32'h0);
    for (int i = 0; i < 64; i++) begin
      set_port(0, 1'b1, 1'b0, 6'(i), 32'h0);
      @(negedge clk);
      chk("rb_grant", 32'(req_ready), 32'h1);
      exp_q.push_back(pat(i));
      @(posedge clk); #1;
      set_port(0, 1'b0, 1'b0, 6'd0, 32'h0);
      lat = -1;
      rd  = '0;
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        if (resp_valid[0] && lat < 0) begin
          lat = c;
          rd  = resp_rdata[31:0];
        end
        @(posedge clk); #1;
      end
      chk("rb_latency", 32'(lat), 32'd1);
      chk("rb_data", rd, exp_q.pop_front());
    end

    // Directed cycle table: RAW across ports, held response, alternating reads.
    tbl[0]  = mk(2'b01, 2'b01, 2'b00, 6'd5, 32'h12345678, 6'd0, 32'h0, 2'b01, 2'b00, 32'h0, 32'h0);
    tbl[1]  = mk(2'b10, 2'b00, 2'b10, 6'd0, 32'h0, 6'd5, 32'h0, 2'b10, 2'b00, 32'h0, 32'h0);
    tbl[2]  = mk(2'b00, 2'b00, 2'b00, 6'd0, 32'h0, 6'd0, 32'h0, 2'b00, 2'b00, 32'h0, 32'h0);
    tbl[3]  = mk(2'b00, 2'b00, 2'b00, 6'd0, 32'h0, 6'd0, 32'h0, 2'b00, 2'b10, 32'h0, 32'h12345678);
    tbl[4]  = mk(2'b00, 2'b00, 2'b10, 6'd0, 32'h0, 6'd0, 32'h0, 2'b00, 2'b10, 32'h0, 32'h12345678);
    tbl[5]  = mk(2'b00, 2'b00, 2'b00, 6'd0, 32'h0, 6'd0, 32'h0, 2'b00, 2'b00, 32'h0, 32'h0);
    tbl[6]  = mk(2'b01, 2'b00, 2'b00, 6'd5, 32'h0, 6'd0, 32'h0, 2'b01, 2'b00, 32'h0, 32'h0);
    tbl[7]  = mk(2'b11, 2'b10, 2'b00, 6'd6, 32'h0, 6'd7, 32'hAAAA0007, 2'b10, 2'b00, 32'h0, 32'h0);
    tbl[8]  = mk(2'b11, 2'b10, 2'b00, 6'd6, 32'h0, 6'd8, 32'hBBBB0008, 2'b10, 2'b01, 32'h12345678, 32'h0);
    tbl[9]  = mk(2'b11, 2'b10, 2'b00, 6'd6, 32'h0, 6'd9, 32'hCCCC0009, 2'b10, 2'b01, 32'h12345678, 32'h0);
    tbl[10] = mk(2'b11, 2'b10, 2'b01, 6'd6, 32'h0, 6'd10, 32'hDDDD000A, 2'b01, 2'b01, 32'h12345678, 32'h0);
    tbl[11] = mk(2'b10, 2'b10, 2'b00, 6'd0, 32'h0, 6'd10, 32'hDDDD000A, 2'b10, 2'b00, 32'h0, 32'h0);
    tbl[12] = mk(2'b00, 2'b00, 2'b00, 6'd0, 32'h0, 6'd0, 32'h0, 2'b00, 2'b01, 32'h06060606, 32'h0);
    tbl[13] = mk(2'b00, 2'b00, 2'b01, 6'd0, 32'h0, 6'd0, 32'h0, 2'b00, 2'b01, 32'h06060606, 32'h0);
    tbl[14] = mk(2'b00, 2'b00, 2'b00, 6'd0, 32'h0, 6'd0, 32'h0, 2'b00, 2'b00, 32'h0, 32'h0);
    tbl[15] = mk(2'b11, 2'b00, 2'b11, 6'd1, 32'h0, 6'd2, 32'h0, 2'b01, 2'b00, 32'h0, 32'h0);
    tbl[16] = mk(2'b11, 2'b00, 2'b11, 6'd1, 32'h0, 6'd2, 32'h0, 2'b10, 2'b00, 32'h0, 32'h0);
    tbl[17] = mk(2'b11, 2'b00, 2'b11, 6'd1, 32'h0, 6'd2, 32'h0, 2'b01, 2'b01, 32'h01010101, 32'h0);
    tbl[18] = mk(2'b11, 2'b00, 2'b11, 6'd1, 32'h0, 6'd2, 32'h0, 2'b10, 2'b10, 32'h0, 32'h02020202);
    tbl[19] = mk(2'b11, 2'b00, 2'b11, 6'd1, 32'h0, 6'd2, 32'h0, 2'b01, 2'b01, 32'h01010101, 32'h0);
    tbl[20] = mk(2'b11, 2'b00, 2'b11, 6'd1, 32'h0, 6'd2, 32'h0, 2'b10, 2'b10, 32'h0, 32'h02020202);
    tbl[21] = mk(2'b01, 2'b00, 2'b11, 6'd1, 32'h0, 6'd0, 32'h0, 2'b01, 2'b01, 32'h01010101, 32'h0);
    tbl[22] = mk(2'b00, 2'b00, 2'b11, 6'd0, 32'h0, 6'd0, 32'h0, 2'b00, 2'b10, 32'h0, 32'h02020202);
    tbl[23] = mk(2'b00, 2'b00, 2'b11, 6'd0, 32'h0, 6'd0, 32'h0, 2'b00, 2'b01, 32'h01010101, 32'h0);
    tbl[24] = mk(2'b00, 2'b00, 2'b11, 6'd0, 32'h0, 6'd0, 32'h0, 2'b00, 2'b00, 32'h0, 32'h0);

    do_reset();
    for (int i = 0; i < 25; i++) begin
      set_port(0, tbl[i].valid[0], tbl[i].we[0], tbl[i].a0, tbl[i].d0);
      set_port(1, tbl[i].valid[1], tbl[i].we[1], tbl[i].a1, tbl[i].d1);
      resp_ready = tbl[i].rr;
      @(negedge clk);
      chk($sformatf("tbl%0d_ready", i), 32'(req_ready), 32'(tbl[i].exp_ready));
      chk($sformatf("tbl%0d_rv", i), 32'(resp_valid), 32'(tbl[i].exp_rv));
      if (tbl[i].exp_rv[0]) chk($sformatf("tbl%0d_r0", i), resp_rdata[31:0], tbl[i].exp_r0);
      if (tbl[i].exp_rv[1]) chk($sformatf("tbl%0d_r1", i), resp_rdata[63:32], tbl[i].exp_r1);
      @(posedge clk); #1;
    end

    // Reset while a port 0 read is in flight: no response, pointer back to 0.
    resp_ready = 2'b11;
    set_port(0, 1'b1, 1'b0, 6'd3, 32'h0);
    set_port(1, 1'b0, 1'b0, 6'd0, 32'h0);
    @(negedge clk);
    chk("mid_pre_grant", 32'(req_ready), 32'h1);
    @(posedge clk); #1;
    reset = 1'b1;
    set_port(1, 1'b1, 1'b0, 6'd4, 32'h0);
    @(negedge clk);
    chk("mid_ready_in_reset", 32'(req_ready), 32'h0);
    chk("mid_rv_in_reset", 32'(resp_valid), 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("mid_first_winner", 32'(req_ready), 32'h1);
    chk("mid_discard", 32'(resp_valid), 32'h0);
    @(posedge clk); #1;
    set_port(0, 1'b0, 1'b0, 6'd0, 32'h0);
    @(negedge clk);
    chk("mid_p1_grant", 32'(req_ready), 32'h2);
    chk("mid_rv_none", 32'(resp_valid), 32'h0);
    @(posedge clk); #1;
    set_port(1, 1'b0, 1'b0, 6'd0, 32'h0);
    @(negedge clk);
    chk("mid_rv_p0", 32'(resp_valid), 32'h1);
    chk("mid_r0", resp_rdata[31:0], 32'h03030303);
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_rv_p1", 32'(resp_valid), 32'h2);
    chk("mid_r1", resp_rdata[63:32], 32'h04040404);
    @(posedge clk); #1;

    // Random traffic against the reference model.
    do_reset();
    m_rr = 0; m_ip = -1; m_id = '0; m_idk = 0;
    for (int i = 0; i < 64; i++) begin m_known[i] = 0; m_mem[i] = '0; end
    for (int p = 0; p < 2; p++) begin m_rv[p] = 0; m_rd[p] = '0; m_rdk[p] = 0; held[p] = 0; end
    for (int cyc = 0; cyc < 2000; cyc++) begin
      for (int p = 0; p < 2; p++) begin
        if (!held[p]) begin
          set_port(p, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                   6'($urandom_range(0, 15)), $urandom);
          req_wmask[p] = $urandom_range(0, 7) != 0;
        end
        resp_ready[p] = $urandom_range(0, 3) != 0;
      end
      @(negedge clk);
      eg = -1;
      for (int k = 0; k < 2; k++) begin
        pp = (m_rr + k) % 2;
        if (eg < 0 && req_valid[pp] &&
            (req_we[pp] || (m_ip != pp && (!m_rv[pp] || resp_ready[pp])))) eg = pp;
      end
      exp_ready = (eg < 0) ? 2'b00 : 2'(1 << eg);
      chk("rnd_ready", 32'(req_ready), 32'(exp_ready));
      if (eg >= 0) begin
        chk("rnd_we", 32'(sram_we), 32'(req_we[eg]));
        chk("rnd_addr", 32'(sram_addr), 32'(req_addr[eg*6 +: 6]));
        if (req_we[eg]) begin
          chk("rnd_din", sram_din, req_wdata[eg*32 +: 32]);
          chk("rnd_wmask", 32'(sram_wmask), 32'(req_wmask[eg]));
        end
      end else begin
        chk("rnd_idle_we", 32'(sram_we), 32'h0);
      end
      for (int p = 0; p < 2; p++) begin
        chk($sformatf("rnd_rv%0d", p), 32'(resp_valid[p]), 32'(m_rv[p]));
        if (m_rv[p] && m_rdk[p]) chk($sformatf("rnd_rd%0d", p), resp_rdata[p*32 +: 32], m_rd[p]);
      end
      for (int p = 0; p < 2; p++) begin
        if (m_ip == p) begin
          m_rv[p] = 1; m_rd[p] = m_id; m_rdk[p] = m_idk;
        end else if (resp_ready[p]) begin
          m_rv[p] = 0;
        end
      end
      m_ip = -1;
      if (eg >= 0) begin
        a = int'(req_addr[eg*6 +: 6]);
        if (req_we[eg]) begin
          if (req_wmask[eg]) begin
            m_mem[a] = req_wdata[eg*32 +: 32];
            m_known[a] = 1;
          end
        end else begin
          m_ip = eg; m_id = m_mem[a]; m_idk = m_known[a];
        end
        m_rr = (eg + 1) % 2;
      end
      for (int p = 0; p < 2; p++) held[p] = req_valid[p] && (eg != p);
      @(posedge clk); #1;
    end

`ifdef SRAM_ARB_PERF_EN
    // Counters: 10 cycles of contention, then port 0 alone past saturation.
    do_reset();
    resp_ready = 2'b11;
    set_port(0, 1'b1, 1'b1, 6'd20, 32'h55);
    set_port(1, 1'b1, 1'b1, 6'd21, 32'h66);
    repeat (10) @(posedge clk);
    #1 set_port(1, 1'b0, 1'b0, 6'd0, 32'h0);
    @(negedge clk);
    chk("perf_g0_10", 32'(perf_grants[15:0]), 32'd5);
    chk("perf_g1_10", 32'(perf_grants[31:16]), 32'd5);
    chk("perf_s0_10", 32'(perf_stalls[15:0]), 32'd5);
    chk("perf_s1_10", 32'(perf_stalls[31:16]), 32'd5);
    repeat (60000) @(posedge clk);
    @(negedge clk);
    chk("perf_g0_60005", 32'(perf_grants[15:0]), 32'd60005);
    repeat (5530) @(posedge clk);
    @(negedge clk);
    chk("perf_g0_max", 32'(perf_grants[15:0]), 32'hFFFF);
    repeat (4470) @(posedge clk);
    @(negedge clk);
    chk("perf_g0_sat", 32'(perf_grants[15:0]), 32'hFFFF);
    chk("perf_g1_end", 32'(perf_grants[31:16]), 32'd5);
    chk("perf_s0_end", 32'(perf_stalls[15:0]), 32'd5);
    chk("perf_s1_end", 32'(perf_stalls[31:16]), 32'd5);
    @(posedge clk); #1;
    set_port(0, 1'b0, 1'b0, 6'd0, 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
